// File: rtl/fetcher_cached_pkg.sv
// rtl/fetcher_cached_pkg.sv - shared fetch state encoding and default widths
package fetcher_cached_pkg;

  localparam int PC_BITS_DEFAULT    = 8;
  localparam int INSTR_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetcher_cached_tag_store.sv
// rtl/fetcher_cached_tag_store.sv - direct-mapped valid/tag/data arrays with combinational lookup
module fetch_tag_store #(
  parameter int PC_BITS     = 8,
  parameter int INSTR_BITS  = 16,
  parameter int CACHE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_BITS-1:0]    lookup_pc,
  output logic                  hit,
  output logic [INSTR_BITS-1:0] hit_data,
  input  logic                  write_enable,
  input  logic [PC_BITS-1:0]    write_pc,
  input  logic [INSTR_BITS-1:0] write_data,
  input  logic                  flush
);

  localparam int IDX_BITS = $clog2(CACHE_DEPTH);
  localparam int TAG_BITS = PC_BITS - IDX_BITS;

  logic [CACHE_DEPTH-1:0] valid;
  logic [TAG_BITS-1:0]    tags  [CACHE_DEPTH];
  logic [INSTR_BITS-1:0]  data  [CACHE_DEPTH];

  logic [IDX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0] lookup_tag;
  logic [IDX_BITS-1:0] write_idx;
  logic [TAG_BITS-1:0] write_tag;

  assign lookup_idx = lookup_pc[IDX_BITS-1:0];
  assign lookup_tag = lookup_pc[PC_BITS-1:IDX_BITS];
  assign write_idx  = write_pc[IDX_BITS-1:0];
  assign write_tag  = write_pc[PC_BITS-1:IDX_BITS];

  assign hit      = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
  assign hit_data = data[lookup_idx];

  // Flush takes priority over a coincident write: the entry must not become valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (write_enable) begin
      valid[write_idx] <= 1'b1;
      tags[write_idx]  <= write_tag;
      data[write_idx]  <= write_data;
    end
  end

endmodule

// File: rtl/fetcher_cached.sv
// rtl/fetcher_cached.sv - instruction fetcher with a direct-mapped buffer in front of program memory
module fetcher_cached
  import fetcher_cached_pkg::*;
#(
  parameter int PC_BITS     = PC_BITS_DEFAULT,
  parameter int INSTR_BITS  = INSTR_BITS_DEFAULT,
  parameter int CACHE_DEPTH = 4,
  parameter int COUNT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  input  logic [PC_BITS-1:0]    pc,
  input  logic                  flush,
  output logic                  mem_read_valid,
  output logic [PC_BITS-1:0]    mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [INSTR_BITS-1:0] mem_read_data,
  output logic                  instruction_ready,
  output logic [INSTR_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0] hit_count,
  output logic [COUNT_BITS-1:0] miss_count
);

  fetch_state_t state, next_state;

  logic                  lookup_hit;
  logic [INSTR_BITS-1:0] lookup_data;
  logic                  fill_done;
  logic                  fill_write;
  logic                  no_alloc;
  logic                  take_hit;
  logic                  take_miss;
  logic [INSTR_BITS-1:0] instr_buf;

  fetch_tag_store #(
    .PC_BITS    (PC_BITS),
    .INSTR_BITS (INSTR_BITS),
    .CACHE_DEPTH(CACHE_DEPTH)
  ) u_tag_store (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (pc),
    .hit         (lookup_hit),
    .hit_data    (lookup_data),
    .write_enable(fill_write),
    .write_pc    (mem_read_address),
    .write_data  (mem_read_data),
    .flush       (flush)
  );

  // A flush in the lookup cycle forbids using the pre-flush contents.
  assign take_hit   = (state == IDLE) && fetch_enable && lookup_hit && !flush;
  assign take_miss  = (state == IDLE) && fetch_enable && !take_hit;
  assign fill_done  = (state == MISS) && mem_read_ready;
  assign fill_write = fill_done && !no_alloc && !flush;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fetch_enable) next_state = take_hit ? DONE : MISS;
      MISS:    if (mem_read_ready) next_state = DONE;
      DONE:    if (!fetch_enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instr_buf        <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      no_alloc         <= 1'b0;
    end else begin
      if (take_hit) begin
        instr_buf <= lookup_data;
        if (hit_count != '1) hit_count <= hit_count + COUNT_BITS'(1);
      end
      if (take_miss) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= pc;
        if (miss_count != '1) miss_count <= miss_count + COUNT_BITS'(1);
      end
      // An outstanding miss that sees a flush returns its data but must not allocate.
      if (fill_done) begin
        instr_buf      <= mem_read_data;
        mem_read_valid <= 1'b0;
        no_alloc       <= 1'b0;
      end else if ((state == MISS) && flush) begin
        no_alloc <= 1'b1;
      end
    end
  end

  assign instruction_ready = (state == DONE);
  assign instruction       = (state == DONE) ? instr_buf : '0;

endmodule

// File: tb/tb_fetcher_cached.sv
// tb/tb_fetcher_cached.sv - directed self-checking bench for fetcher_cached
module tb_fetcher_cached;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [7:0]  pc;
  logic        flush;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        instruction_ready;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        s_mem_read_valid;
  logic [7:0]  s_mem_read_address;
  logic        s_instruction_ready;
  logic [15:0] s_instruction;
  logic [1:0]  s_hit_count;
  logic [1:0]  s_miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetcher_cached #(.PC_BITS(8), .INSTR_BITS(16), .CACHE_DEPTH(4), .COUNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .pc(pc), .flush(flush),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .instruction_ready(instruction_ready), .instruction(instruction),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  fetcher_cached #(.PC_BITS(8), .INSTR_BITS(16), .CACHE_DEPTH(4), .COUNT_BITS(2)) dut_sat (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .pc(pc), .flush(flush),
    .mem_read_valid(s_mem_read_valid), .mem_read_address(s_mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .instruction_ready(s_instruction_ready), .instruction(s_instruction),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [15:0] d);
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    step();
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
  endtask

  task automatic release_fetch();
    fetch_enable = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; fetch_enable = 1'b0; pc = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    step(); step();
    reset = 1'b1;
    check_val("rst_mrv", 32'(mem_read_valid), 32'h0);
    check_val("rst_addr", 32'(mem_read_address), 32'h0);
    check_val("rst_ready", 32'(instruction_ready), 32'h0);
    check_val("rst_instr", 32'(instruction), 32'h0);
    check_val("rst_hits", 32'(hit_count), 32'h0);
    check_val("rst_misses", 32'(miss_count), 32'h0);

    // cold miss, memory answers on the third cycle of MISS
    pc = 8'h05; fetch_enable = 1'b1;
    step();
    check_val("cold_mrv", 32'(mem_read_valid), 32'h1);
    check_val("cold_addr", 32'(mem_read_address), 32'h05);
    check_val("cold_notready", 32'(instruction_ready), 32'h0);
    step();
    step();
    check_val("cold_mrv_held", 32'(mem_read_valid), 32'h1);
    check_val("cold_addr_held", 32'(mem_read_address), 32'h05);
    respond(16'hA1B2);
    check_val("cold_ready", 32'(instruction_ready), 32'h1);
    check_val("cold_instr", 32'(instruction), 32'hA1B2);
    check_val("cold_mrv_drop", 32'(mem_read_valid), 32'h0);
    check_val("cold_misses", 32'(miss_count), 32'h1);
    check_val("cold_hits", 32'(hit_count), 32'h0);
    release_fetch();
    check_val("idle_instr_gated", 32'(instruction), 32'h0);
    check_val("idle_notready", 32'(instruction_ready), 32'h0);

    // hit on the same pc
    fetch_enable = 1'b1;
    step();
    check_val("hit_ready", 32'(instruction_ready), 32'h1);
    check_val("hit_instr", 32'(instruction), 32'hA1B2);
    check_val("hit_no_mrv", 32'(mem_read_valid), 32'h0);
    check_val("hit_count1", 32'(hit_count), 32'h1);
    release_fetch();

    // conflict: 0x09 shares index 1 with 0x05
    pc = 8'h09; fetch_enable = 1'b1;
    step();
    check_val("conf_mrv", 32'(mem_read_valid), 32'h1);
    check_val("conf_addr", 32'(mem_read_address), 32'h09);
    respond(16'h1234);
    check_val("conf_instr", 32'(instruction), 32'h1234);
    release_fetch();
    pc = 8'h05; fetch_enable = 1'b1;
    step();
    check_val("conf_evict_mrv", 32'(mem_read_valid), 32'h1);
    check_val("conf_misses", 32'(miss_count), 32'h3);
    respond(16'hA1B2);
    release_fetch();

    // flush while a miss is outstanding: data returned, not allocated
    pc = 8'h07; fetch_enable = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fl_still_miss", 32'(mem_read_valid), 32'h1);
    respond(16'h0F0F);
    check_val("fl_ready", 32'(instruction_ready), 32'h1);
    check_val("fl_instr", 32'(instruction), 32'h0F0F);
    release_fetch();
    fetch_enable = 1'b1;
    step();
    check_val("fl_noalloc_mrv", 32'(mem_read_valid), 32'h1);
    check_val("fl_noalloc_misses", 32'(miss_count), 32'h5);
    respond(16'h0F0F);
    release_fetch();

    // flush alongside a lookup of a cached pc forces a miss
    fetch_enable = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flidle_mrv", 32'(mem_read_valid), 32'h1);
    check_val("flidle_hits", 32'(hit_count), 32'h1);
    check_val("flidle_misses", 32'(miss_count), 32'h6);
    respond(16'h0F0F);
    release_fetch();

    // five hits; the 2-bit instance saturates
    for (int i = 0; i < 5; i++) begin
      fetch_enable = 1'b1;
      step();
      check_val("sat_hit_ready", 32'(instruction_ready), 32'h1);
      if (i < 4) release_fetch();
    end
    check_val("hits_wide", 32'(hit_count), 32'h6);
    check_val("hits_sat", 32'(s_hit_count), 32'h3);
    check_val("misses_sat", 32'(s_miss_count), 32'h3);

    // flush in DONE keeps the presented instruction
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fldone_ready", 32'(instruction_ready), 32'h1);
    check_val("fldone_instr", 32'(instruction), 32'h0F0F);
    release_fetch();

    // reset in the middle of a miss
    fetch_enable = 1'b1;
    step();
    check_val("rmid_mrv", 32'(mem_read_valid), 32'h1);
    reset = 1'b0;
    step();
    reset = 1'b1; fetch_enable = 1'b0;
    check_val("rmid_mrv_drop", 32'(mem_read_valid), 32'h0);
    check_val("rmid_hits", 32'(hit_count), 32'h0);
    check_val("rmid_misses", 32'(miss_count), 32'h0);
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    step();
    step();
    mem_read_ready = 1'b0;
    check_val("stray_ready", 32'(instruction_ready), 32'h0);
    check_val("stray_instr", 32'(instruction), 32'h0);
    check_val("stray_mrv", 32'(mem_read_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetcher_cached.md
Name: fetcher_cached

Overview:
Parametrised instruction fetcher for a core. It adds a small direct-mapped instruction buffer in front of the program-memory read channel, so repeated PCs (loops) return in one cycle instead of a full memory round trip. It keeps the core-side fetch_enable / instruction_ready handshake, and adds a flush input and hit/miss counters. It sits between each core's scheduler and the program-memory controller.

Parameters:
PC_BITS, 8, program counter / memory address width
INSTR_BITS, 16, instruction / memory data width
CACHE_DEPTH, 4, number of buffer entries; power of two, >= 2
COUNT_BITS, 16, width of hit/miss counters

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset asserted)
fetch_enable  in  1  scheduler request; held high until instruction consumed
pc  in  PC_BITS  fetch address, stable while fetch_enable high
flush  in  1  one-cycle pulse: invalidate all buffer entries
mem_read_valid  out  1  program-memory read request
mem_read_address  out  PC_BITS  read address
mem_read_ready  in  1  memory response strobe; data valid same cycle
mem_read_data  in  INSTR_BITS  returned instruction
instruction_ready  out  1  high in DONE
instruction  out  INSTR_BITS  fetched instruction in DONE, else 0
hit_count  out  COUNT_BITS  saturating count of buffer hits
miss_count  out  COUNT_BITS  saturating count of memory fetches

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; all entry valid bits=0; mem_read_valid=0; mem_read_address=0.
  - instruction buffer=0; hit_count=miss_count=0; instruction_ready=0; instruction=0.
  - Reset mid-miss abandons the request. mem_read_valid drops on that edge, and a later mem_read_ready is ignored in IDLE.
- Address split: index = pc[log2(CACHE_DEPTH)-1:0]; tag = remaining upper pc bits. Each entry holds valid, tag, INSTR_BITS data.
- States: IDLE, MISS, DONE.
- IDLE, fetch_enable=1, hit (entry valid and tag match):
  - Latch entry data; hit_count++ (saturate at all-ones); go to DONE.
  - instruction_ready is high the cycle after the request: latency 1.
- IDLE, fetch_enable=1, miss:
  - mem_read_valid<=1; mem_read_address<=pc; miss_count++ (saturating); go to MISS.
- MISS: mem_read_valid and mem_read_address held stable until mem_read_ready==1 is sampled. On that edge:
  - latch mem_read_data into the output buffer;
  - write entry[index] with valid=1, tag, data;
  - mem_read_valid<=0; go to DONE.
  - Miss latency = memory latency + 1 cycle.
- DONE: instruction_ready=1, instruction=latched data. Stay until fetch_enable==0 is sampled, then go to IDLE. A new request needs at least one cycle of fetch_enable low.
- mem_read_ready outside MISS is ignored.
- flush:
  - Clears all valid bits on that edge.
  - A fill coinciding with flush, or any fill completing for a miss issued before a flush, still returns its instruction to the core but does NOT allocate; flush wins.
  - Implementation: a "no-allocate" flag set by flush during MISS, cleared on return.
  - flush in IDLE together with fetch_enable: the lookup uses the pre-flush contents, but no hit is allowed. Flush forces a miss that cycle.
  - flush in DONE does not disturb the presented instruction.
- Counters saturate; they never wrap.
- instruction is combinationally gated to 0 outside DONE.

Decomposition:
- Shared package: state encoding (IDLE/MISS/DONE) and the default widths (PC_BITS, INSTR_BITS), shared with the scheduler and memory controller.
- One natural sub-module: fetch_tag_store. It holds the valid/tag/data arrays, a combinational lookup (hit, data) and a synchronous write/flush port. The FSM, memory handshake and counters stay in fetcher_cached.

Test Plan:
- Cold miss: reset, pc=0x05, fetch_enable=1, memory ready after 3 cycles with data 0xA1B2 -> mem_read_valid high with address 0x05 until ready; instruction_ready the cycle after ready; instruction=0xA1B2; miss_count=1, hit_count=0.
- Hit: drop fetch_enable 1 cycle, re-request pc=0x05 -> no mem_read_valid; instruction_ready 1 cycle after request; instruction=0xA1B2; hit_count=1.
- Conflict: fill pc=0x05, then request pc=0x09 (same index, CACHE_DEPTH=4) -> miss, data 0x1234; re-request 0x05 -> miss again; miss_count=3.
- Flush during miss: pc=0x07 miss, flush pulse before ready, data 0x0F0F -> instruction=0x0F0F; re-request 0x07 -> miss (not allocated).
- Reset mid-miss: reset=0 while in MISS -> mem_read_valid=0 next edge; counters 0; a stray mem_read_ready while in IDLE produces no instruction_ready.
- Saturation: COUNT_BITS=2, 5 hits -> hit_count stays 3.
